coef_reader: RTL and testbench
==============================

Name: coef_reader

Overview:
Sequencer that reads the matched-filter coefficient ROMs and streams the coefficients out. It drives the shared address/enable of the real and imaginary coefficient ROMs (1-cycle registered read, output held while enable low). It presents each complex coefficient over a valid/ready stream to the filter MAC. It sits between the coefficient ROMs and the correlator datapath; one sweep is issued per start pulse.

Parameters:
ORDER, 60, last coefficient index; each sweep delivers ORDER+1 coefficients.
ADDR_W, 32, ROM address width.
DATA_W, 16, coefficient width (two's complement, Q1.15).
IDX_W, 8, width of coef_idx; must satisfy 2^IDX_W > ORDER.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin sweep; sampled in IDLE only
reverse  in  1  1 = sweep addresses ORDER..0 (time-reversed); latched on accepted start
abort  in  1  terminate sweep; returns to IDLE next cycle
busy  out  1  high in PRIME and STREAM
done  out  1  one-cycle pulse after the last coefficient is accepted
rom_en  out  1  ROM read enable (shared by real and imaginary ROMs)
rom_addr  out  ADDR_W  ROM address; upper bits zero
rom_re_data  in  DATA_W  real ROM output
rom_im_data  in  DATA_W  imaginary ROM output
coef_valid  out  1  coefficient stream valid
coef_ready  in  1  consumer ready
coef_re  out  DATA_W  real coefficient
coef_im  out  DATA_W  imaginary coefficient
coef_idx  out  IDX_W  logical index 0..ORDER of the coefficient presented
coef_last  out  1  high with coef_valid when coef_idx == ORDER

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, rom_en=0, rom_addr=0, coef_valid=0, coef_idx=0, coef_last=0, reverse latch=0. The coef_re/coef_im passthrough follows the ROM (the ROM itself is reset to 0).
- States: IDLE, PRIME, STREAM, DONE.
- IDLE: start=1 -> PRIME. Latch reverse. Set idx=0. Ignore start in all other states.
- PRIME (1 cycle): rom_en=1, rom_addr=first address (0, or ORDER if reversed) -> STREAM.
- STREAM:
  - coef_valid=1. coef_re/coef_im come combinationally from the ROM outputs.
  - Handshake = coef_valid & coef_ready.
  - On a handshake with idx<ORDER: rom_en=1, rom_addr=next address, idx increments. The next coefficient appears the following cycle, so zero-bubble throughput is 1 coefficient per cycle.
  - With coef_ready=0: rom_en=0. The ROM holds its output, so coef_re/coef_im/coef_idx stay stable. Data must not change while valid and not ready.
  - On a handshake with idx==ORDER: go to DONE. No ROM read is issued.
- DONE: done=1 for one cycle, coef_valid=0 -> IDLE. A start in DONE is ignored.
- Address map: rom_addr = reverse_l ? ORDER-idx : idx, zero-extended to ADDR_W. It never leaves 0..ORDER.
- abort: has priority over a handshake in the same cycle; that coefficient counts as not accepted. From PRIME/STREAM/DONE go to IDLE on the next edge, with coef_valid=0 and rom_en=0 that same cycle; no done pulse. In IDLE, abort has no effect.
- Start latency: start accepted at edge k -> PRIME in cycle k+1 -> coef_valid=1 in cycle k+2.
- busy drops in the DONE cycle.
- rom_en is combinational from state, coef_ready and idx. rom_addr is combinational from idx and state.

Optional Feature:
COEF_CONJ_EN:
- Defined: coef_im = saturating negate of rom_im_data (conjugate for matched filtering). -32768 maps to 32767; all other values are negated exactly. The path stays combinational, with no added latency.
- Undefined: coef_im = rom_im_data unchanged.
- coef_re is unaffected in both cases.

Decomposition:
- Shared package: DATA_W, ORDER default, state enum {IDLE, PRIME, STREAM, DONE}, Q1.15 MAX/MIN constants.
- Sub-module sat_negate (DATA_W-wide combinational saturating negate), instantiated only under COEF_CONJ_EN.
- FSM and counter stay in coef_reader.

Test Plan:
- Forward sweep, coef_ready held 1, ROM model loaded with the reference coefficient tables: start -> coef_valid rises 2 cycles later; 61 consecutive handshakes with coef_idx 0..60 matching ROM[0..60]; coef_last only on idx 60; done pulses once; busy falls.
- reverse=1: first coefficient = ROM[60] (0x0000 imag), last = ROM[0] (re per table, imag 0xF3C7); rom_addr sequence 60..0.
- Random coef_ready backpressure (≈50%): no data change while valid & !ready; rom_en=0 on every stalled cycle; exactly 61 coefficients delivered in order.
- abort at idx 20 during a stall, and abort at PRIME: coef_valid low the next cycle, no done pulse, and a subsequent start restarts at idx 0.
- Async rst asserted mid-STREAM, between clock edges: all outputs reach reset values immediately; start held during busy/DONE is ignored (no second sweep).
- COEF_CONJ_EN defined: ROM imag 0x8000 -> coef_im 0x7FFF; ROM imag 0x1844 -> 0xE7BC; undefined build passes 0x8000 through unchanged.

Source files
------------

// File: rtl/coef_reader_pkg.sv
// Shared constants for the coefficient reader: default sizes, FSM state codes, Q1.15 limits.
package coef_reader_pkg;
  localparam int COEF_DATA_W = 16;
  localparam int COEF_ORDER  = 60;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [COEF_DATA_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [COEF_DATA_W-1:0] Q15_MIN = 16'h8000;
endpackage

// File: rtl/coef_reader_sat_negate.sv
// Combinational two's-complement negate, saturating the most negative code to the most positive.
// Zero latency; no flow control.
module sat_negate
  import coef_reader_pkg::*;
#(
  parameter int DATA_W = COEF_DATA_W
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

  assign dout = (din == MIN_V) ? MAX_V : (~din + DATA_W'(1));
endmodule

// File: rtl/coef_reader.sv
// Sweeps the coefficient ROMs once per start and streams ORDER+1 complex taps over valid/ready;
// first tap 2 cycles after start, 1 tap/cycle, ROM reads stall with ready. COEF_CONJ_EN conjugates imag.
module coef_reader
  import coef_reader_pkg::*;
#(
  parameter int ORDER  = COEF_ORDER,
  parameter int ADDR_W = 32,
  parameter int DATA_W = COEF_DATA_W,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reverse,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re_data,
  input  logic [DATA_W-1:0] rom_im_data,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [DATA_W-1:0] coef_re,
  output logic [DATA_W-1:0] coef_im,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              coef_last
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ORDER);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             rev_l;
  logic             at_last;
  logic             hs;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] addr_idx;

  assign at_last    = (idx == LAST);
  assign coef_valid = (state == ST_STREAM) & ~abort;
  assign hs         = coef_valid & coef_ready;
  assign rom_en     = ~abort & ((state == ST_PRIME) | (hs & ~at_last));
  assign busy       = (state == ST_PRIME) | (state == ST_STREAM);
  assign done       = (state == ST_DONE) & ~abort;
  assign coef_idx   = idx;
  assign coef_last  = coef_valid & at_last;
  assign coef_re    = rom_re_data;

  // While streaming the address always points at the tap after the one on the bus,
  // clamped at the last tap so it never leaves 0..ORDER.
  always_comb begin
    sel_idx = idx;
    if (state == ST_STREAM && !at_last) sel_idx = idx + IDX_W'(1);
    addr_idx = rev_l ? (LAST - sel_idx) : sel_idx;
    rom_addr = '0;
    if (busy) rom_addr = ADDR_W'(addr_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      rev_l <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_PRIME;
            rev_l <= reverse;
            idx   <= '0;
          end
        end
        ST_PRIME: state <= abort ? ST_IDLE : ST_STREAM;
        ST_STREAM: begin
          if (abort) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else if (hs) begin
            if (at_last) state <= ST_DONE;
            else         idx   <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

`ifdef COEF_CONJ_EN
  sat_negate #(.DATA_W(DATA_W)) u_conj (.din(rom_im_data), .dout(coef_im));
`else
  assign coef_im = rom_im_data;
`endif
endmodule

// File: tb/tb_coef_reader.sv
// Directed bench for coef_reader with a registered ROM model and a per-cycle stream scoreboard.
module tb_coef_reader;
  localparam int ORDER  = 60;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start = 1'b0, reverse = 1'b0, abort = 1'b0, coef_ready = 1'b0;
  logic              busy, done, rom_en, coef_valid, coef_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_re, rom_im, coef_re, coef_im;
  logic [IDX_W-1:0]  coef_idx;

  always #5 clk = ~clk;

  coef_reader #(.ORDER(ORDER), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .reverse(reverse), .abort(abort),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_re_data(rom_re), .rom_im_data(rom_im),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_re(coef_re), .coef_im(coef_im), .coef_idx(coef_idx), .coef_last(coef_last)
  );

  logic [15:0] re_tab [0:60];
  logic [15:0] im_tab [0:60];

  // Coefficient ROM pair: registered read, holds while disabled, resets to zero.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_re <= '0;
      rom_im <= '0;
    end else if (rom_en && rom_addr <= 60) begin
      rom_re <= re_tab[rom_addr[5:0]];
      rom_im <= im_tab[rom_addr[5:0]];
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_im(input logic [15:0] x);
`ifdef COEF_CONJ_EN
    if (x == 16'h8000) return 16'h7FFF;
    return 16'(17'h10000 - {1'b0, x});
`else
    return x;
`endif
  endfunction

  // Scoreboard state: the logical tap the stream must present next.
  bit          model_rev = 0;
  int          exp_pos = 0, hs_cnt = 0, last_cnt = 0, done_cnt = 0, stall_cnt = 0;
  bit          prev_stall = 0;
  logic [39:0] prev_dat;
  logic [15:0] first_re, first_im, last_re, last_im;
  logic [15:0] got_im [0:60];
  int          addr_q[$];

  always @(negedge clk) begin
    int ri;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (coef_valid) begin
        if (exp_pos > ORDER) begin
          chk("extra_tap", exp_pos, ORDER);
        end else begin
          ri = model_rev ? ORDER - exp_pos : exp_pos;
          chk("idx", coef_idx, exp_pos);
          chk("re", coef_re, re_tab[ri]);
          chk("im", coef_im, model_im(im_tab[ri]));
          chk("last", coef_last, exp_pos == ORDER);
          if (prev_stall) chk("hold", {coef_re, coef_im, coef_idx}, prev_dat);
          if (!coef_ready) begin
            chk("stall_en", rom_en, 0);
            stall_cnt++;
          end else begin
            if (exp_pos == 0) begin
              first_re = coef_re;
              first_im = coef_im;
            end
            last_re = coef_re;
            last_im = coef_im;
            got_im[exp_pos] = coef_im;
            if (coef_last) last_cnt++;
            hs_cnt++;
            exp_pos++;
          end
        end
        prev_stall = !coef_ready;
        prev_dat   = {coef_re, coef_im, coef_idx};
      end else begin
        chk("last_idle", coef_last, 0);
        prev_stall = 0;
      end
      if (rom_en) begin
        chk("addr_range", rom_addr <= 60, 1);
        addr_q.push_back(int'(rom_addr));
      end
      if (done) done_cnt++;
    end
  end

  task automatic begin_sweep(input bit rev, input bit hold);
    @(posedge clk); #1;
    reverse = rev; start = 1'b1; coef_ready = 1'b1;
    model_rev = rev; exp_pos = 0; hs_cnt = 0; last_cnt = 0; stall_cnt = 0;
    addr_q.delete();
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic run_sweep(input bit rev, input bit bp, input bit hold, input int maxcyc);
    int d0, mism;
    bit seen;
    d0 = done_cnt;
    begin_sweep(rev, hold);
    chk("prime_busy", busy, 1);
    chk("prime_valid", coef_valid, 0);
    chk("prime_en", rom_en, 1);
    chk("prime_addr", rom_addr, rev ? 60 : 0);
    @(posedge clk); #1;
    chk("valid_latency", coef_valid, 1);
    seen = 0;
    for (int n = 0; n < maxcyc && !seen; n++) begin
      coef_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        start = 1'b0;
        chk("done_busy", busy, 0);
        chk("done_valid", coef_valid, 0);
      end
    end
    if (!seen) chk("sweep_timeout", 0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_resweep", busy, 0);
    chk("done_once", done_cnt - d0, 1);
    chk("hs_count", hs_cnt, 61);
    chk("last_once", last_cnt, 1);
    chk("addr_count", addr_q.size(), 61);
    mism = 0;
    foreach (addr_q[k]) if (addr_q[k] != (rev ? ORDER - k : k)) mism++;
    chk("addr_seq", mism, 0);
  endtask

  initial begin
    int d0;
    bit found;
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit found;
    for (int i = 0; i <= 60; i++) begin
      re_tab[i] = 16'(i * 517 - 9000);
      im_tab[i] = 16'(i * 1234 + 100);
      got_im[i] = '0;
    end
    im_tab[0]  = 16'hF3C7;
    im_tab[5]  = 16'h8000;
    im_tab[7]  = 16'h1844;
    im_tab[60] = 16'h0000;

    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", rom_en, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_idx", coef_idx, 0);
    chk("rst_last", coef_last, 0);
    chk("rst_re", coef_re, 0);
    chk("rst_im", coef_im, 0);
    #10 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Forward sweep, no backpressure.
    run_sweep(0, 0, 0, 300);
    chk("fwd_first_re", first_re, 16'hDCD8);
    chk("fwd_last_re", last_re, 16'h5604);
`ifdef COEF_CONJ_EN
    chk("fwd_first_im", first_im, 16'h0C39);
    chk("conj_min", got_im[5], 16'h7FFF);
    chk("conj_1844", got_im[7], 16'hE7BC);
`else
    chk("fwd_first_im", first_im, 16'hF3C7);
    chk("pass_min", got_im[5], 16'h8000);
    chk("pass_1844", got_im[7], 16'h1844);
`endif

    // Time-reversed sweep.
    run_sweep(1, 0, 0, 300);
    chk("rev_first_re", first_re, 16'h5604);
    chk("rev_first_im", first_im, 16'h0000);
    chk("rev_last_re", last_re, 16'hDCD8);
`ifdef COEF_CONJ_EN
    chk("rev_last_im", last_im, 16'h0C39);
`else
    chk("rev_last_im", last_im, 16'hF3C7);
`endif

    // Random backpressure.
    run_sweep(0, 1, 0, 2000);
    chk("bp_stalled", stall_cnt > 0, 1);

    // Abort at idx 20 after a stall, with ready high in the abort cycle.
    d0 = done_cnt;
    begin_sweep(0, 0);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk); #1;
      if (coef_valid && coef_idx == 20) begin
        coef_ready = 1'b0;
        found = 1;
      end
    end
    chk("abort_reach20", found, 1);
    @(posedge clk); #1;
    chk("abort_stall_idx", coef_idx, 20);
    abort = 1'b1; coef_ready = 1'b1;
    #1;
    chk("abort_valid", coef_valid, 0);
    chk("abort_en", rom_en, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_valid", coef_valid, 0);
    chk("abort_hs", hs_cnt, 20);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    run_sweep(0, 0, 0, 300);

    // Abort during PRIME.
    d0 = done_cnt;
    begin_sweep(1, 0);
    chk("prime_abort_busy", busy, 1);
    abort = 1'b1;
    #1;
    chk("prime_abort_en", rom_en, 0);
    chk("prime_abort_valid", coef_valid, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("prime_abort_idle", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("prime_abort_novalid", coef_valid, 0);
    chk("prime_abort_hs", hs_cnt, 0);
    chk("prime_abort_no_done", done_cnt - d0, 0);

    // Start held high through the sweep and DONE: exactly one sweep.
    run_sweep(0, 0, 1, 300);

    // Asynchronous reset between clock edges while streaming.
    begin_sweep(0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_valid", coef_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", coef_valid, 0);
    chk("arst_en", rom_en, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_idx", coef_idx, 0);
    chk("arst_last", coef_last, 0);
    chk("arst_done", done, 0);
    chk("arst_re", coef_re, 0);
    chk("arst_im", coef_im, 0);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_stay_idle", busy, 0);
    run_sweep(1, 1, 0, 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
